// File: rtl/dequantization_8in8_if.sv
// rtl/dequantization_8in8_if.sv - block-level bus for the 8x8 three-channel dequantizer
//
// Purpose: carries the start/hold request, the three quantized input blocks,
// the three dequantized output blocks and the completion flag between the
// requester (master) and dequantization_8in8 (slave).
//
// Signals:
//   enable       master->slave  start request in IDLE, hold request in DONE
//   Y_in/Cr_in/Cb_in  master->slave  64 x IN_W signed coefficients, (r,c) at [(8r+c)*IN_W +: IN_W]
//   Y_out/Cr_out/Cb_out  slave->master  64 x OUT_W signed coefficients, (r,c) at [(8r+c)*OUT_W +: OUT_W]
//   data_valid   slave->master  high while a completed block is presented
interface dequantization_8in8_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 14
);
    logic                  enable;
    logic [64*IN_W-1:0]    Y_in;
    logic [64*IN_W-1:0]    Cr_in;
    logic [64*IN_W-1:0]    Cb_in;
    logic [64*OUT_W-1:0]   Y_out;
    logic [64*OUT_W-1:0]   Cr_out;
    logic [64*OUT_W-1:0]   Cb_out;
    logic                  data_valid;

    modport master (
        output enable, Y_in, Cr_in, Cb_in,
        input  Y_out, Cr_out, Cb_out, data_valid
    );

    modport slave (
        input  enable, Y_in, Cr_in, Cb_in,
        output Y_out, Cr_out, Cb_out, data_valid
    );
endinterface

// File: rtl/dequantization_8in8.sv
// rtl/dequantization_8in8.sv - JPEG 8x8 Y/Cr/Cb dequantizer, one row per cycle
//
// Purpose: on a start request, snapshots three 8x8 blocks of quantized
// coefficients, then multiplies one row of each channel per clock by the JPEG
// Annex K luminance (Y) or chrominance (Cr, Cb) table entry, saturating to the
// signed OUT_W range. After row 7 the block is flagged valid and held while
// enable stays high.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears state, snapshots, outputs)
//   bus    dequantization_8in8_if.slave (enable, *_in, *_out, data_valid)
module dequantization_8in8 #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    dequantization_8in8_if.slave  bus
);

    localparam int IN_BUS  = 64 * IN_W;
    localparam int OUT_BUS = 64 * OUT_W;
    // Signed coefficient times a 9-bit signed (zero-extended 8-bit) table entry.
    localparam int PROD_W  = IN_W + 9;

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [2:0]          row_q, row_d;
    logic [IN_BUS-1:0]   snap_y_q, snap_y_d;
    logic [IN_BUS-1:0]   snap_cr_q, snap_cr_d;
    logic [IN_BUS-1:0]   snap_cb_q, snap_cb_d;
    logic [OUT_BUS-1:0]  y_out_q, y_out_d;
    logic [OUT_BUS-1:0]  cr_out_q, cr_out_d;
    logic [OUT_BUS-1:0]  cb_out_q, cb_out_d;
    logic                valid_q, valid_d;
    logic [63:0]         qy_vec;
    logic [63:0]         qc_vec;

    // Luminance table row; column c sits in byte c (column 0 in the low byte).
    function automatic logic [63:0] qy_row(input logic [2:0] r);
        case (r)
            3'd0:    qy_row = {8'd61,  8'd51,  8'd40,  8'd24,  8'd16,  8'd10,  8'd11,  8'd16};
            3'd1:    qy_row = {8'd55,  8'd60,  8'd58,  8'd26,  8'd19,  8'd14,  8'd12,  8'd12};
            3'd2:    qy_row = {8'd56,  8'd69,  8'd57,  8'd40,  8'd24,  8'd16,  8'd13,  8'd14};
            3'd3:    qy_row = {8'd62,  8'd80,  8'd87,  8'd51,  8'd29,  8'd22,  8'd17,  8'd14};
            3'd4:    qy_row = {8'd77,  8'd103, 8'd109, 8'd68,  8'd56,  8'd37,  8'd22,  8'd18};
            3'd5:    qy_row = {8'd92,  8'd113, 8'd104, 8'd81,  8'd64,  8'd55,  8'd35,  8'd24};
            3'd6:    qy_row = {8'd101, 8'd120, 8'd121, 8'd103, 8'd87,  8'd78,  8'd64,  8'd49};
            default: qy_row = {8'd99,  8'd103, 8'd100, 8'd112, 8'd98,  8'd95,  8'd92,  8'd72};
        endcase
    endfunction

    // Chrominance table row; only rows 0-3 differ from the flat 99 fill.
    function automatic logic [63:0] qc_row(input logic [2:0] r);
        case (r)
            3'd0:    qc_row = {8'd99, 8'd99, 8'd99, 8'd99, 8'd47, 8'd24, 8'd18, 8'd17};
            3'd1:    qc_row = {8'd99, 8'd99, 8'd99, 8'd99, 8'd66, 8'd26, 8'd21, 8'd18};
            3'd2:    qc_row = {8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd56, 8'd26, 8'd24};
            3'd3:    qc_row = {8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd66, 8'd47};
            default: qc_row = {8{8'd99}};
        endcase
    endfunction

    // Exact product, then clamp into the signed OUT_W range.
    function automatic logic [OUT_W-1:0] dequant(input logic [IN_W-1:0] coef,
                                                 input logic [7:0]      q);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'($signed(coef)) * PROD_W'($signed({1'b0, q}));
        if (prod > SAT_MAX)
            dequant = SAT_MAX[OUT_W-1:0];
        else if (prod < SAT_MIN)
            dequant = SAT_MIN[OUT_W-1:0];
        else
            dequant = prod[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        snap_y_d  = snap_y_q;
        snap_cr_d = snap_cr_q;
        snap_cb_d = snap_cb_q;
        y_out_d   = y_out_q;
        cr_out_d  = cr_out_q;
        cb_out_d  = cb_out_q;
        valid_d   = valid_q;
        qy_vec    = qy_row(row_q);
        qc_vec    = qc_row(row_q);

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    snap_y_d  = bus.Y_in;
                    snap_cr_d = bus.Cr_in;
                    snap_cb_d = bus.Cb_in;
                    valid_d   = 1'b0;
                    row_d     = 3'd0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Only the current row's fields are rewritten; later rows keep
                // the previous block until their turn comes.
                for (int c = 0; c < 8; c++) begin
                    int idx;
                    idx = int'(row_q) * 8 + c;
                    y_out_d[idx*OUT_W +: OUT_W]  = dequant(snap_y_q[idx*IN_W +: IN_W],  qy_vec[c*8 +: 8]);
                    cr_out_d[idx*OUT_W +: OUT_W] = dequant(snap_cr_q[idx*IN_W +: IN_W], qc_vec[c*8 +: 8]);
                    cb_out_d[idx*OUT_W +: OUT_W] = dequant(snap_cb_q[idx*IN_W +: IN_W], qc_vec[c*8 +: 8]);
                end
                if (row_q == 3'd7) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= 3'd0;
            snap_y_q  <= '0;
            snap_cr_q <= '0;
            snap_cb_q <= '0;
            y_out_q   <= '0;
            cr_out_q  <= '0;
            cb_out_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            snap_y_q  <= snap_y_d;
            snap_cr_q <= snap_cr_d;
            snap_cb_q <= snap_cb_d;
            y_out_q   <= y_out_d;
            cr_out_q  <= cr_out_d;
            cb_out_q  <= cb_out_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.Y_out      = y_out_q;
    assign bus.Cr_out     = cr_out_q;
    assign bus.Cb_out     = cb_out_q;
    assign bus.data_valid = valid_q;

endmodule
